lcd: RTL and testbench
======================

LCD -- requirements
Module: lcd

Interface
REQ-001 Parameter WIDTH1, default 16: number of characters in line1.
REQ-002 Parameter WIDTH2, default 16: number of characters in line2.
REQ-003 Parameter HEIGHT, default 2: number of physical display rows (1 or 2).
REQ-004 Parameter E_CYC, default 12: clock cycles LCD_E is held high per byte.
REQ-005 Parameter CMD_WAIT, default 2000: idle cycles after each byte, except clear.
REQ-006 Parameter CLR_WAIT, default 82000: idle cycles after the clear command (0x01).
REQ-007 The block SHALL use one clock; reset is synchronous and active-low.
REQ-008 Port CLK, input, 1 bit: rising-edge clock.
REQ-009 Port RST, input, 1 bit: synchronous reset, active-low.
REQ-010 Port line1, input, 8*WIDTH1 bits: ASCII text for row 1; first character in bits [8*WIDTH1-1 -: 8].
REQ-011 Port line2, input, 8*WIDTH2 bits: ASCII text for row 2, with the same packing as line1.
REQ-012 Port two_line, input, 1 bit: 1 selects 2-line mode and writes line2; 0 selects 1-line mode.
REQ-013 Port start, input, 1 bit: level-sensitive request to run the init-and-write sequence.
REQ-014 Port LCD_E, output, 1 bit: HD44780 enable strobe.
REQ-015 Port LCD_RS, output, 1 bit: register select (0 = command, 1 = data).
REQ-016 Port LCD_DATA, output, 8 bits: HD44780 8-bit data bus.

Function
REQ-017 States SHALL be IDLE, SETUP, PULSE, WAIT and NEXT; all outputs SHALL be registered.
REQ-018 In IDLE, a cycle with start=1 SHALL latch line1, line2 and two_line and begin the sequence on the next cycle.
REQ-019 While the sequence is running, start SHALL be ignored; start held high for several cycles SHALL produce exactly one sequence.
REQ-020 If start is still 1 when the sequence returns to IDLE, a new sequence SHALL begin.
REQ-021 Byte order SHALL be:
- function set: 0x38 if the latched two_line=1, else 0x30;
- 0x0C (display on, cursor off);
- 0x06 (entry mode, increment);
- 0x01 (clear);
- WIDTH1 data bytes of line1;
- if two_line=1 and HEIGHT>=2: 0x80|0x40 = 0xC0, then WIDTH2 data bytes of line2.
REQ-022 Command bytes SHALL have LCD_RS=0; line character bytes SHALL have LCD_RS=1.
REQ-023 Per byte, the cycles SHALL run:
- SETUP, 1 cycle: LCD_RS and LCD_DATA driven, LCD_E=0;
- PULSE, E_CYC cycles: LCD_E=1, data stable;
- WAIT: LCD_E=0 for CMD_WAIT cycles, or CLR_WAIT cycles after 0x01;
- NEXT, 1 cycle: select the next byte or return to IDLE.
REQ-024 LCD_DATA and LCD_RS SHALL stay stable from SETUP through the end of WAIT; they change only in SETUP.
REQ-025 After the last byte's WAIT, the FSM SHALL return to IDLE with LCD_E=0; LCD_DATA and LCD_RS SHALL hold their last values.
REQ-026 The character index SHALL count from 0 to WIDTHn-1.
REQ-027 Character i SHALL be bits [8*(WIDTHn-i)-1 -: 8] of the latched line.
REQ-028 Changes on line1, line2 or two_line during a sequence SHALL have no effect on it.
REQ-029 LCD_E SHALL never be high in two consecutive PULSE phases without an intervening low WAIT.

Reset
REQ-030 With RST=0 at a rising CLK edge, the next state SHALL be:
- LCD_E=0, LCD_RS=0, LCD_DATA=0x00;
- FSM in IDLE;
- all counters cleared.
REQ-031 Reset asserted mid-sequence SHALL abort it immediately: no further LCD_E pulse, and the FSM SHALL wait in IDLE for a new start.
REQ-032 start SHALL be ignored while RST=0.

Verification
REQ-033 Scenario: WIDTH1=5, WIDTH2=5, HEIGHT=2, E_CYC=2, CMD_WAIT=4, CLR_WAIT=8, line1="Hello", line2="World", two_line=1, start high for 2 cycles.
- Required LCD_E pulses (RS, DATA): 38,0C,06,01 (RS=0); 48,65,6C,6C,6F (RS=1); C0 (RS=0); 57,6F,72,6C,64 (RS=1).
- Exactly 15 pulses, then IDLE.
REQ-034 Same parameters with two_line=0:
- first byte 0x30;
- no 0xC0 byte and no line2 bytes;
- exactly 9 pulses.
REQ-035 Each pulse is exactly E_CYC=2 cycles high.
- The 0x01 pulse is followed by at least 8 low cycles.
- Every other pulse is followed by at least 4 low cycles.
- DATA and RS do not change while E=1.
REQ-036 Assert RST=0 for one cycle during the third character pulse.
- Required: next cycle E=0, RS=0, DATA=0x00.
- No further pulses until the next start.
REQ-037 Change line1 to "XXXXX" mid-sequence: the emitted characters remain "Hello".
REQ-038 Start held high through a full sequence: a second identical sequence follows immediately after returning to IDLE.

Source files
------------

// File: rtl/lcd.sv
// rtl/lcd.sv - HD44780 8-bit init-and-write sequencer for one or two text rows
//
// Purpose: on a start request, latches the text and mode, then sends function
// set, display on, entry mode and clear, followed by the row 1 characters and,
// in 2-line mode, a set-DDRAM-address 0x40 command and the row 2 characters.
// Each byte goes through SETUP (bus driven), PULSE (E high E_CYC cycles),
// WAIT (E low CMD_WAIT or CLR_WAIT cycles) and NEXT.
//
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous reset, active low
//   line1     row 1 text, first character in the top byte
//   line2     row 2 text, same packing
//   two_line  1 = 2-line mode and write line2
//   start     level-sensitive sequence request
//   LCD_E     enable strobe (registered)
//   LCD_RS    register select, 0 = command, 1 = data (registered)
//   LCD_DATA  8-bit data bus (registered)
module lcd #(
    parameter int WIDTH1   = 16,
    parameter int WIDTH2   = 16,
    parameter int HEIGHT   = 2,
    parameter int E_CYC    = 12,
    parameter int CMD_WAIT = 2000,
    parameter int CLR_WAIT = 82000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [8*WIDTH1-1:0] line1,
    input  logic [8*WIDTH2-1:0] line2,
    input  logic                two_line,
    input  logic                start,
    output logic                LCD_E,
    output logic                LCD_RS,
    output logic [7:0]          LCD_DATA
);

    localparam int MAXC = (CLR_WAIT > CMD_WAIT)
                        ? ((CLR_WAIT > E_CYC) ? CLR_WAIT : E_CYC)
                        : ((CMD_WAIT > E_CYC) ? CMD_WAIT : E_CYC);
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(5 + WIDTH1 + WIDTH2 + 1);

    localparam logic [CW-1:0] E_LAST   = CW'(E_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

    // Byte index layout: 0..3 init commands, 4..3+WIDTH1 row 1,
    // 4+WIDTH1 the 0xC0 address command, then row 2.
    localparam logic [IW-1:0] CLR_IDX = IW'(3);
    localparam logic [IW-1:0] LAST_1  = IW'(3 + WIDTH1);
    localparam logic [IW-1:0] LAST_2  = IW'(4 + WIDTH1 + WIDTH2);
    localparam bit            ROWS2   = (HEIGHT >= 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [8*WIDTH1-1:0] l1_q, l1_d;
    logic [8*WIDTH2-1:0] l2_q, l2_d;
    logic                tl_q, tl_d;
    logic                e_q, e_d;
    logic                rs_q, rs_d;
    logic [7:0]          data_q, data_d;

    // Returns {rs, data} for byte index i of a sequence.
    function automatic logic [8:0] byte_at(input int i,
                                           input logic [8*WIDTH1-1:0] l1,
                                           input logic [8*WIDTH2-1:0] l2,
                                           input logic tl);
        logic [8:0] r;
        if (i == 0)                r = {1'b0, (tl ? 8'h38 : 8'h30)};
        else if (i == 1)           r = {1'b0, 8'h0C};
        else if (i == 2)           r = {1'b0, 8'h06};
        else if (i == 3)           r = {1'b0, 8'h01};
        else if (i < 4 + WIDTH1)   r = {1'b1, 8'(l1 >> (8 * (WIDTH1 - 1 - (i - 4))))};
        else if (i == 4 + WIDTH1)  r = {1'b0, 8'hC0};
        else                       r = {1'b1, 8'(l2 >> (8 * (WIDTH2 - 1 - (i - 5 - WIDTH1))))};
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            tl_q    <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            tl_q    <= tl_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        tl_d    = tl_q;
        e_d     = 1'b0;
        rs_d    = rs_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    l1_d    = line1;
                    l2_d    = line2;
                    tl_d    = two_line;
                    idx_d   = '0;
                    state_d = S_SETUP;
                    // Bus is loaded on entry so it is already valid during SETUP.
                    {rs_d, data_d} = byte_at(0, line1, line2, two_line);
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                e_d     = 1'b1;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == E_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    e_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == ((idx_q == CLR_IDX) ? CLR_LAST : CMD_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (idx_q == ((tl_q && ROWS2) ? LAST_2 : LAST_1)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SETUP;
                    {rs_d, data_d} = byte_at(int'(idx_d), l1_q, l2_q, tl_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign LCD_E    = e_q;
    assign LCD_RS   = rs_q;
    assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd.sv
// tb/tb_lcd.sv - scoreboard testbench for the lcd sequencer
module tb_lcd;

    localparam int W1  = 5;
    localparam int W2  = 5;
    localparam int HT  = 2;
    localparam int EC  = 2;
    localparam int CWT = 4;
    localparam int CLW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] l1;
    logic [39:0] l2;
    logic        tl;
    logic        st;
    logic        e;
    logic        rs;
    logic [7:0]  d;

    always #5 clk = ~clk;

    lcd #(
        .WIDTH1(W1), .WIDTH2(W2), .HEIGHT(HT),
        .E_CYC(EC), .CMD_WAIT(CWT), .CLR_WAIT(CLW)
    ) dut (
        .CLK(clk), .RST(rst_n), .line1(l1), .line2(l2),
        .two_line(tl), .start(st),
        .LCD_E(e), .LCD_RS(rs), .LCD_DATA(d)
    );

    int         checks = 0;
    int         fails  = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_seq(input logic [39:0] a, input logic [39:0] b, input logic t);
        exp_q.push_back({1'b0, (t ? 8'h38 : 8'h30)});
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        for (int i = 0; i < W1; i++) exp_q.push_back({1'b1, a[8*(W1-i)-1 -: 8]});
        if (t) begin
            exp_q.push_back(9'h0C0);
            for (int i = 0; i < W2; i++) exp_q.push_back({1'b1, b[8*(W2-i)-1 -: 8]});
        end
    endtask

    // Monitor: every rising E pops one expected byte; pulse width, bus
    // stability and the low gap before the next pulse are checked too.
    logic       e_prev = 1'b0;
    logic       have_prev = 1'b0;
    logic       prev_clr = 1'b0;
    int         hi = 0;
    int         lo = 0;
    logic [8:0] cur = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev    = 1'b0;
            have_prev = 1'b0;
            hi        = 0;
            lo        = 0;
        end else begin
            if (e && !e_prev) begin
                if (have_prev) begin
                    checks++;
                    if (lo < (prev_clr ? CLW : CWT)) begin
                        fails++;
                        $display("FAIL low_gap actual=%0d required>=%0d", lo, (prev_clr ? CLW : CWT));
                    end
                end
                cur = {rs, d};
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse actual=%0h required=none", {rs, d});
                end else begin
                    chk("pulse_byte", {23'd0, rs, d}, {23'd0, exp_q.pop_front()});
                end
                hi = 1;
            end else if (e) begin
                hi++;
                chk("stable_during_e", {23'd0, rs, d}, {23'd0, cur});
            end else if (e_prev) begin
                chk("pulse_width", hi, EC);
                have_prev = 1'b1;
                prev_clr  = (cur == 9'h001);
                lo = 1;
            end else begin
                lo++;
            end
            e_prev = e;
        end
    end

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int cycles);
        st = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 st = 1'b0;
    endtask

    initial begin
        int n;
        st = 1'b0;
        tl = 1'b1;
        l1 = "Hello";
        l2 = "World";

        // Reset, with start asserted during reset (must be ignored).
        repeat (2) @(posedge clk);
        #1 st = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_e", {31'd0, e}, 0);
        chk("reset_rs", {31'd0, rs}, 0);
        chk("reset_data", {24'd0, d}, 0);
        st = 1'b0;
        rs_release();
        repeat (20) @(posedge clk);
        #1;
        chk("idle_after_reset_e", {31'd0, e}, 0);

        // Two-line sequence, start held 2 cycles: 15 pulses.
        push_seq("Hello", "World", 1'b1);
        pulse_start(2);
        drain(2000);
        chk("t1_hold_data", {24'd0, d}, 32'h64);
        chk("t1_hold_rs", {31'd0, rs}, 1);
        chk("t1_idle_e", {31'd0, e}, 0);

        // One-line sequence: 9 pulses, first 0x30.
        tl = 1'b0;
        push_seq("Hello", "World", 1'b0);
        pulse_start(2);
        drain(2000);
        chk("t2_hold_data", {24'd0, d}, 32'h6F);
        chk("t2_hold_rs", {31'd0, rs}, 1);

        // line1 changed mid-sequence: still "Hello".
        push_seq("Hello", "World", 1'b0);
        pulse_start(1);
        n = 0;
        while (exp_q.size() > 6 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 l1 = "XXXXX";
        tl = 1'b1;
        drain(2000);
        l1 = "Hello";

        // Reset during the third character pulse.
        push_seq("Hello", "World", 1'b1);
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        pulse_start(1);
        n = 0;
        while (!(e && exp_q.size() == 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_reached_char3", {31'd0, e}, 1);
        chk("t4_char3_data", {24'd0, d}, 32'h6C);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_abort_e", {31'd0, e}, 0);
        chk("t4_abort_rs", {31'd0, rs}, 0);
        chk("t4_abort_data", {24'd0, d}, 0);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("t4_still_idle_data", {24'd0, d}, 0);

        // Start held through a full sequence: exactly two sequences.
        tl = 1'b0;
        push_seq("Hello", "World", 1'b0);
        push_seq("Hello", "World", 1'b0);
        st = 1'b1;
        n = 0;
        while (exp_q.size() > 8 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1 st = 1'b0;
        drain(2000);
        chk("t5_hold_data", {24'd0, d}, 32'h6F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    task automatic rs_release();
        rst_n = 1'b1;
    endtask

endmodule
